// File: rtl/load_store_sequencer_pkg.sv
// Shared types, funct3 encodings and size helpers for the load/store sequencer.
package load_store_sequencer_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] data_t;

   // RV32I load/store funct3 encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ0  = 3'd1,
      WAIT0 = 3'd2,
      REQ1  = 3'd3,
      WAIT1 = 3'd4,
      RESP  = 3'd5
   } lsu_state_t;

   // Access size in bytes; funct3[1:0] selects byte/half/word for both signed and unsigned forms
   function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // Byte-lane mask for an access of this size starting at lane 0
   function automatic logic [3:0] size_mask(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Loads accept b/h/w/bu/hu; stores accept only b/h/w
   function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
      if (is_store)
         return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      else
         return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                (funct3 == F3_BU) || (funct3 == F3_HU);
   endfunction

endpackage

// File: rtl/load_store_sequencer_data_align.sv
// lsu_data_align: purely combinational lane steering.
// Stores: size mask and data are shifted across a 64-bit window spanning two words;
// the low word feeds beat 0 and the high word feeds beat 1.
// Loads: the two captured beat words are concatenated, shifted down by the byte
// offset, and the low bytes are sign- or zero-extended by funct3.
module lsu_data_align
   import load_store_sequencer_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic [1:0] off,
   input  data_t      store_data,
   input  data_t      load_word0,
   input  data_t      load_word1,
   output logic [3:0] strb0,
   output logic [3:0] strb1,
   output data_t      wdata0,
   output data_t      wdata1,
   output data_t      load_data
);

   logic [3:0]  mask;
   data_t       masked_data;
   logic [7:0]  strb64;
   logic [63:0] wdata64;
   logic [63:0] word64;

   // Store path: clear unused lanes, then shift strobes and data into place
   always_comb begin
      mask        = size_mask(funct3);
      masked_data = store_data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
      strb64      = {4'b0000, mask} << off;
      wdata64     = {32'h0, masked_data} << {off, 3'b000};
      strb0       = strb64[3:0];
      strb1       = strb64[7:4];
      wdata0      = wdata64[31:0];
      wdata1      = wdata64[63:32];
   end

   // Load path: merge both beats, align to lane 0, then extend
   always_comb begin
      word64 = {load_word1, load_word0} >> {off, 3'b000};
      case (funct3)
         F3_B:    load_data = {{24{word64[7]}}, word64[7:0]};
         F3_BU:   load_data = {24'h0, word64[7:0]};
         F3_H:    load_data = {{16{word64[15]}}, word64[15:0]};
         F3_HU:   load_data = {16'h0, word64[15:0]};
         default: load_data = word64[31:0];
      endcase
   end

endmodule

// File: rtl/load_store_sequencer.sv
// load_store_sequencer: accepts one load/store at a time from execute, issues one or
// two word-aligned beats on the req/gnt/rvalid memory bus, and returns a single
// completion pulse carrying the extended load result or an error flag.
module load_store_sequencer
   import load_store_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  addr_t       req_addr,
   input  data_t       req_wdata,
   output logic        resp_valid,
   output data_t       resp_rdata,
   output logic        resp_error,
   output logic        mem_req,
   output logic        mem_we,
   output addr_t       mem_addr,
   output logic [3:0]  mem_wstrb,
   output data_t       mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  data_t       mem_rdata
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   // Abort fires in the last allowed cycle so a beat waits at most TIMEOUT_CYCLES cycles
   localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_t state;
   lsu_state_t state_next;

   logic             is_store_q;
   logic [2:0]       funct3_q;
   addr_t            addr_q;
   data_t            wdata_q;
   logic             split_q;
   logic             err_q;
   data_t            word0_q;
   data_t            word1_q;
   logic [CNT_W-1:0] cnt;

   logic       accept;
   logic       req_legal;
   logic       req_split;
   logic       timeout_hit;
   logic       abort;
   logic       latch0;
   logic       latch1;
   addr_t      beat0_addr;
   addr_t      beat1_addr;
   logic [3:0] strb0;
   logic [3:0] strb1;
   data_t      wdata0;
   data_t      wdata1;
   data_t      load_data;

   assign req_ready   = (state == IDLE);
   assign accept      = req_valid && req_ready;
   assign req_legal   = funct3_legal(req_is_store, req_funct3);
   // Offset plus size past one word means the access straddles two words
   assign req_split   = ({1'b0, req_addr[1:0]} + size_bytes(req_funct3)) > 3'd4;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
   assign beat0_addr  = {addr_q[31:2], 2'b00};
   assign beat1_addr  = beat0_addr + 32'd4;

   lsu_data_align u_align (
      .funct3     (funct3_q),
      .off        (addr_q[1:0]),
      .store_data (wdata_q),
      .load_word0 (word0_q),
      .load_word1 (word1_q),
      .strb0      (strb0),
      .strb1      (strb1),
      .wdata0     (wdata0),
      .wdata1     (wdata1),
      .load_data  (load_data)
   );

   // State register
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state and memory-bus outputs
   // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
   always_comb begin
      state_next = state;
      abort      = 1'b0;
      latch0     = 1'b0;
      latch1     = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wstrb  = '0;
      mem_wdata  = '0;
      case (state)
         IDLE: begin
            if (req_valid) state_next = req_legal ? REQ0 : RESP;
         end
         REQ0: begin
            mem_req  = 1'b1;
            mem_we   = is_store_q;
            mem_addr = beat0_addr;
            if (is_store_q) begin
               mem_wstrb = strb0;
               mem_wdata = wdata0;
            end
            if (mem_gnt) begin
               if (is_store_q) state_next = split_q ? REQ1 : RESP;
               else            state_next = WAIT0;
            end else if (timeout_hit) begin
               abort      = 1'b1;
               state_next = RESP;
            end
         end
         WAIT0: begin
            if (mem_rvalid) begin
               latch0     = 1'b1;
               state_next = split_q ? REQ1 : RESP;
            end else if (timeout_hit) begin
               abort      = 1'b1;
               state_next = RESP;
            end
         end
         REQ1: begin
            mem_req  = 1'b1;
            mem_we   = is_store_q;
            mem_addr = beat1_addr;
            if (is_store_q) begin
               mem_wstrb = strb1;
               mem_wdata = wdata1;
            end
            if (mem_gnt) begin
               state_next = is_store_q ? RESP : WAIT1;
            end else if (timeout_hit) begin
               abort      = 1'b1;
               state_next = RESP;
            end
         end
         WAIT1: begin
            if (mem_rvalid) begin
               latch1     = 1'b1;
               state_next = RESP;
            end else if (timeout_hit) begin
               abort      = 1'b1;
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request capture, error flag and load beat data
   // NOTE: these are a handful of control/data flops, not a memory array, so resetting them is cheap and keeps outputs defined.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         is_store_q <= 1'b0;
         funct3_q   <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         split_q    <= 1'b0;
         err_q      <= 1'b0;
         word0_q    <= '0;
         word1_q    <= '0;
      end else begin
         if (accept) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            split_q    <= req_split;
            err_q      <= !req_legal;
         end else if (abort) begin
            err_q <= 1'b1;
         end
         if (latch0) word0_q <= mem_rdata;
         if (latch1) word1_q <= mem_rdata;
      end
   end

   // Per-beat wait counter, restarted whenever the FSM changes state
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                    cnt <= '0;
      else if (state_next != state) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
   end

   // Completion outputs, forced to zero outside the response cycle
   assign resp_valid = (state == RESP);
   assign resp_error = resp_valid && err_q;
   assign resp_rdata = (resp_valid && !err_q && !is_store_q) ? load_data : '0;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer: a table of single transactions with
// hand-computed beats/results, plus hand sequences for timeout and mid-op reset.
module tb_load_store_sequencer;
   import load_store_sequencer_pkg::*;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_errors = 0;

   load_store_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_is_store (req_is_store),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_error   (resp_error),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wstrb    (mem_wstrb),
      .mem_wdata    (mem_wdata),
      .mem_gnt      (mem_gnt),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        is_store;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] word0;
      logic [31:0] word1;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_beats;
      logic [31:0] a0;
      logic [3:0]  s0;
      logic [31:0] d0;
      logic [31:0] a1;
      logic [3:0]  s1;
      logic [31:0] d1;
      int          exp_lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic err, input logic [31:0] rdata, input int beats,
                               input logic [31:0] a0, input logic [3:0] s0, input logic [31:0] d0,
                               input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1,
                               input int lat);
      vec_t v;
      v.name = name; v.is_store = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
      v.word0 = w0; v.word1 = w1; v.exp_err = err; v.exp_rdata = rdata; v.exp_beats = beats;
      v.a0 = a0; v.s0 = s0; v.d0 = d0; v.a1 = a1; v.s1 = s1; v.d1 = d1; v.exp_lat = lat;
      return v;
   endfunction

   // Present one request; returns at the negedge just after the accepting edge
   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
      @(negedge clk);
      req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0; req_is_store = ~st; req_funct3 = 3'b111;
      req_addr = 32'hFFFF_FFFF; req_wdata = 32'hA5A5_A5A5;
   endtask

   // Run one vector with a simple memory responder (gnt after gnt_delay cycles, rvalid one cycle later)
   task automatic run_vec(input vec_t v, input int gnt_delay);
      int          cyc;
      int          beats;
      int          lat;
      int          wait_cnt;
      logic        pend;
      logic        got;
      logic        r_err;
      logic [31:0] r_data;
      logic [31:0] pend_data;
      logic [31:0] ba [2];
      logic [3:0]  bs [2];
      logic [31:0] bd [2];
      beats = 0; lat = 0; wait_cnt = 0; pend = 1'b0; got = 1'b0;
      r_err = 1'b0; r_data = 32'h0; pend_data = 32'h0;
      for (int i = 0; i < 2; i++) begin
         ba[i] = 32'h0; bs[i] = 4'h0; bd[i] = 32'h0;
      end
      check({v.name, " ready"}, {31'h0, req_ready}, 32'h1);
      issue(v.is_store, v.f3, v.addr, v.wdata);
      cyc = 1;
      while (cyc <= 40 && !got) begin
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
         if (resp_valid) begin
            got = 1'b1; lat = cyc; r_err = resp_error; r_data = resp_rdata;
         end else begin
            if (pend) begin
               mem_rvalid = 1'b1; mem_rdata = pend_data; pend = 1'b0;
            end
            if (mem_req) begin
               if (wait_cnt >= gnt_delay) begin
                  check({v.name, " we"}, {31'h0, mem_we}, {31'h0, v.is_store});
                  if (beats < 2) begin
                     ba[beats] = mem_addr; bs[beats] = mem_wstrb; bd[beats] = mem_wdata;
                  end
                  mem_gnt = 1'b1;
                  if (!mem_we) begin
                     pend = 1'b1; pend_data = (beats == 0) ? v.word0 : v.word1;
                  end
                  beats++; wait_cnt = 0;
               end else begin
                  wait_cnt++;
               end
            end
            @(negedge clk);
            cyc++;
         end
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      check({v.name, " resp_seen"}, {31'h0, got}, 32'h1);
      check({v.name, " latency"}, 32'(lat), 32'(v.exp_lat + gnt_delay));
      check({v.name, " error"}, {31'h0, r_err}, {31'h0, v.exp_err});
      check({v.name, " rdata"}, r_data, v.exp_rdata);
      check({v.name, " beats"}, 32'(beats), 32'(v.exp_beats));
      check({v.name, " addr0"}, ba[0], v.a0);
      check({v.name, " strb0"}, {28'h0, bs[0]}, {28'h0, v.s0});
      check({v.name, " wdata0"}, bd[0], v.d0);
      check({v.name, " addr1"}, ba[1], v.a1);
      check({v.name, " strb1"}, {28'h0, bs[1]}, {28'h0, v.s1});
      check({v.name, " wdata1"}, bd[1], v.d1);
      @(negedge clk);
      check({v.name, " pulse_end"}, {31'h0, resp_valid}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int req_cycles;
      int cyc;
      logic got;
      logic r_err;
      logic [31:0] r_data;

      reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

      //           name        st  f3     addr          wdata         word0         word1         err  rdata         bt a0            s0     d0            a1            s1     d1            lat
      vecs.push_back(mk("lw100",   0, F3_W,  32'h100,      32'h0,        32'hDEADBEEF, 32'h0,        0, 32'hDEADBEEF, 1, 32'h100,      4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        3));
      vecs.push_back(mk("lb103",   0, F3_B,  32'h103,      32'h0,        32'h80112233, 32'h0,        0, 32'hFFFFFF80, 1, 32'h100,      4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        3));
      vecs.push_back(mk("lbu103",  0, F3_BU, 32'h103,      32'h0,        32'h80112233, 32'h0,        0, 32'h00000080, 1, 32'h100,      4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        3));
      vecs.push_back(mk("lh102",   0, F3_H,  32'h102,      32'h0,        32'h80112233, 32'h0,        0, 32'hFFFF8011, 1, 32'h100,      4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        3));
      vecs.push_back(mk("lhu100",  0, F3_HU, 32'h100,      32'h0,        32'h80112233, 32'h0,        0, 32'h00002233, 1, 32'h100,      4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        3));
      vecs.push_back(mk("lhu101",  0, F3_HU, 32'h101,      32'h0,        32'h80112233, 32'h0,        0, 32'h00001122, 1, 32'h100,      4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        3));
      vecs.push_back(mk("lw102",   0, F3_W,  32'h102,      32'h0,        32'h11223344, 32'h55667788, 0, 32'h77881122, 2, 32'h100,      4'h0, 32'h0,        32'h104,      4'h0, 32'h0,        5));
      vecs.push_back(mk("lh103",   0, F3_H,  32'h103,      32'h0,        32'h11223344, 32'h55667788, 0, 32'hFFFF8811, 2, 32'h100,      4'h0, 32'h0,        32'h104,      4'h0, 32'h0,        5));
      vecs.push_back(mk("lwwrap",  0, F3_W,  32'hFFFFFFFE, 32'h0,        32'hAABBCCDD, 32'h11223344, 0, 32'h3344AABB, 2, 32'hFFFFFFFC, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        5));
      vecs.push_back(mk("sh103",   1, F3_H,  32'h103,      32'h0000ABCD, 32'h0,        32'h0,        0, 32'h0,        2, 32'h100,      4'h8, 32'hCD000000, 32'h104,      4'h1, 32'h000000AB, 3));
      vecs.push_back(mk("sw200",   1, F3_W,  32'h200,      32'h12345678, 32'h0,        32'h0,        0, 32'h0,        1, 32'h200,      4'hF, 32'h12345678, 32'h0,        4'h0, 32'h0,        2));
      vecs.push_back(mk("sb201",   1, F3_B,  32'h201,      32'hFFFFFF5A, 32'h0,        32'h0,        0, 32'h0,        1, 32'h200,      4'h2, 32'h00005A00, 32'h0,        4'h0, 32'h0,        2));
      vecs.push_back(mk("sw106",   1, F3_W,  32'h106,      32'hA1B2C3D4, 32'h0,        32'h0,        0, 32'h0,        2, 32'h104,      4'hC, 32'hC3D40000, 32'h108,      4'h3, 32'h0000A1B2, 3));
      vecs.push_back(mk("ill_ld",  0, 3'b011,32'h100,      32'h0,        32'h0,        32'h0,        1, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        1));
      vecs.push_back(mk("ill_st",  1, 3'b100,32'h100,      32'h12345678, 32'h0,        32'h0,        1, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        1));

      // Reset state
      repeat (3) @(negedge clk);
      check("rst req_ready", {31'h0, req_ready}, 32'h1);
      check("rst mem_req", {31'h0, mem_req}, 32'h0);
      check("rst resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rst mem_addr", mem_addr, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst outputs", {mem_req, mem_we, mem_wstrb, resp_valid, resp_error}, 32'h0);
      check("post_rst wdata", mem_wdata, 32'h0);
      check("post_rst rdata", resp_rdata, 32'h0);

      foreach (vecs[i]) run_vec(vecs[i], 0);

      // Grant held off two cycles: still within the timeout budget
      run_vec(vecs[0], 2);

      // Timeout with gnt held low
      issue(1'b0, F3_W, 32'h300, 32'h0);
      req_cycles = 0; got = 1'b0; r_err = 1'b0; r_data = 32'hFFFF_FFFF; cyc = 1;
      while (cyc <= 20 && !got) begin
         if (resp_valid) begin
            got = 1'b1; r_err = resp_error; r_data = resp_rdata;
         end else begin
            if (mem_req) req_cycles++;
            @(negedge clk);
            cyc++;
         end
      end
      check("to_gnt resp_seen", {31'h0, got}, 32'h1);
      check("to_gnt req_cycles", 32'(req_cycles), 32'(TO));
      check("to_gnt error", {31'h0, r_err}, 32'h1);
      check("to_gnt rdata", r_data, 32'h0);
      @(negedge clk);
      check("to_gnt idle", {31'h0, req_ready}, 32'h1);

      // Timeout waiting on rvalid, then a late rvalid in IDLE must be ignored
      issue(1'b0, F3_W, 32'h304, 32'h0);
      check("to_rv req", {31'h0, mem_req}, 32'h1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      got = 1'b0; r_err = 1'b0; cyc = 0;
      while (cyc < 20 && !got) begin
         if (resp_valid) begin
            got = 1'b1; r_err = resp_error;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      check("to_rv resp_seen", {31'h0, got}, 32'h1);
      check("to_rv error", {31'h0, r_err}, 32'h1);
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("late_rv ignored", {31'h0, resp_valid}, 32'h0);

      // Reset during WAIT1 of a split load
      issue(1'b0, F3_W, 32'h102, 32'h0);
      check("mid_rst req0", {31'h0, mem_req}, 32'h1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("mid_rst req1_addr", mem_addr, 32'h104);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      check("mid_rst in_wait1", {31'h0, mem_req}, 32'h0);
      #2 reset = 1'b1;
      #1;
      check("mid_rst outputs", {mem_req, mem_we, mem_wstrb, resp_valid, resp_error}, 32'h0);
      check("mid_rst addr", mem_addr, 32'h0);
      check("mid_rst ready", {31'h0, req_ready}, 32'h1);
      @(negedge clk);
      reset = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h55667788;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("stray_rv no_resp", {31'h0, resp_valid}, 32'h0);
         @(negedge clk);
      end
      run_vec(mk("lw200", 0, F3_W, 32'h200, 32'h0, 32'hCAFEF00D, 32'h0, 0, 32'hCAFEF00D, 1,
                 32'h200, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 3), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
